// File: rtl/ls_port_arbiter.sv
// LocalStore port arbiter: odd-pipe LS unit vs DMA/preload channel, with atomic DMA bursts and tagged read return.
// Optional DMA starvation guard enabled by defining LS_ARB_STARVE_GUARD_EN.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | per-beat arbitration, pipe has priority (unless DMA starved)
// ST_DMA_LOCK | DMA burst owns the port, pipe blocked until exit
module ls_port_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 128,
    parameter int RD_LAT     = 1,
    parameter int LOCK_MAX   = 8,
    parameter int STARVE_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              pipe_valid,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_ready,
    output logic              pipe_rvalid,
    output logic [DATA_W-1:0] pipe_rdata,
    input  logic              dma_valid,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_last,
    output logic              dma_ready,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              ls_en,
    output logic              ls_we,
    output logic [ADDR_W-1:0] ls_addr,
    output logic [DATA_W-1:0] ls_wdata,
    input  logic [DATA_W-1:0] ls_rdata,
    output logic              lock_active,
    output logic              dma_starved
);

    localparam int LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_DMA_LOCK = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic             pipe_gnt, dma_gnt;
    logic             starve_pref;

    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_o;
    logic              ret_v, ret_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        pipe_gnt   = 1'b0;
        dma_gnt    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (starve_pref && dma_valid) begin
                    dma_gnt = 1'b1;
                end else if (!flush && pipe_valid) begin
                    pipe_gnt = 1'b1;
                end else if (dma_valid) begin
                    dma_gnt = 1'b1;
                end
                if (dma_gnt && !dma_last) begin
                    state_d    = ST_DMA_LOCK;
                    lock_cnt_d = LCW'(1);
                end
            end
            ST_DMA_LOCK: begin
                dma_gnt = dma_valid;
                // the beat reaching LOCK_MAX is the last one of this locked run
                if (!dma_valid || dma_last || lock_cnt_q == LCW'(LOCK_MAX - 1)) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                lock_cnt_d = '0;
            end
        endcase
        if (!rst_n) begin
            pipe_gnt = 1'b0;
            dma_gnt  = 1'b0;
        end
    end

    assign pipe_ready  = pipe_gnt;
    assign dma_ready   = dma_gnt;
    assign ls_en       = pipe_gnt | dma_gnt;
    assign ls_we       = pipe_gnt ? pipe_we    : (dma_gnt & dma_we);
    assign ls_addr     = pipe_gnt ? pipe_addr  : (dma_gnt ? dma_addr  : '0);
    assign ls_wdata    = pipe_gnt ? pipe_wdata : (dma_gnt ? dma_wdata : '0);
    assign lock_active = (state_q == ST_DMA_LOCK);

    // Read tags: valid + owner (1 = DMA). A flush kills every in-flight pipe tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v[0] <= 1'b0;
            tag_o[0] <= 1'b0;
        end else begin
            tag_v[0] <= ls_en & ~ls_we;
            tag_o[0] <= dma_gnt;
        end
    end

    for (genvar g = 1; g < RD_LAT; g++) begin : g_tag
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_v[g] <= 1'b0;
                tag_o[g] <= 1'b0;
            end else begin
                tag_v[g] <= tag_v[g-1] & ~(flush & ~tag_o[g-1]);
                tag_o[g] <= tag_o[g-1];
            end
        end
    end

    assign ret_v = tag_v[RD_LAT-1];
    assign ret_o = tag_o[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_rvalid <= 1'b0;
            pipe_rdata  <= '0;
            dma_rvalid  <= 1'b0;
            dma_rdata   <= '0;
        end else begin
            pipe_rvalid <= ret_v & ~ret_o & ~flush;
            dma_rvalid  <= ret_v & ret_o;
            if (ret_v && !ret_o && !flush) begin
                pipe_rdata <= ls_rdata;
            end
            if (ret_v && ret_o) begin
                dma_rdata <= ls_rdata;
            end
        end
    end

`ifdef LS_ARB_STARVE_GUARD_EN
    localparam int WCW = $clog2(STARVE_MAX + 1);

    logic [WCW-1:0] wait_cnt_q;
    logic           starved_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            starved_q  <= 1'b0;
        end else if (dma_gnt) begin
            wait_cnt_q <= '0;
            starved_q  <= 1'b0;
        end else if (dma_valid) begin
            if (wait_cnt_q != WCW'(STARVE_MAX)) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (wait_cnt_q >= WCW'(STARVE_MAX - 1)) begin
                starved_q <= 1'b1;
            end
        end
    end

    assign starve_pref = starved_q;
    assign dma_starved = starved_q;
`else
    assign starve_pref = 1'b0;
    assign dma_starved = 1'b0;
`endif

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Self-checking bench for ls_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_ls_port_arbiter;

    localparam int AW         = 15;
    localparam int DW         = 128;
    localparam int RD_LAT     = 1;
    localparam int LOCK_MAX   = 8;
    localparam int STARVE_MAX = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          pipe_valid = 1'b0, pipe_we = 1'b0;
    logic [AW-1:0] pipe_addr = '0;
    logic [DW-1:0] pipe_wdata = '0;
    logic          pipe_ready, pipe_rvalid;
    logic [DW-1:0] pipe_rdata;
    logic          dma_valid = 1'b0, dma_we = 1'b0, dma_last = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic          dma_ready, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          ls_en, ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [DW-1:0] ls_rdata = '0;
    logic          lock_active, dma_starved;

    always #5 clk = ~clk;

    ls_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .pipe_valid(pipe_valid), .pipe_we(pipe_we), .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata), .pipe_ready(pipe_ready), .pipe_rvalid(pipe_rvalid),
        .pipe_rdata(pipe_rdata),
        .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_last(dma_last), .dma_ready(dma_ready), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata),
        .ls_en(ls_en), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .lock_active(lock_active), .dma_starved(dma_starved)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // reference model: pending reads with the cycle their data is on ls_rdata
    typedef struct {
        logic owner_dma;
        int   cap;
    } rd_t;
    rd_t pend[$];

    int            m_beats;     // beats of current locked DMA run, 0 = not locked
    int            m_waits;
    logic          m_starved;
    logic          m_pgnt, m_dgnt;
    logic          e_prv, e_drv;
    logic [DW-1:0] e_prd, e_drd;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_beats   = 0;
        m_waits   = 0;
        m_starved = 1'b0;
        pend.delete();
        e_prv = 1'b0;
        e_drv = 1'b0;
        e_prd = '0;
        e_drd = '0;
    endtask

    task automatic step(input logic r, input logic f,
                        input logic pv, input logic pwe, input logic [AW-1:0] pa,
                        input logic [DW-1:0] pwd,
                        input logic dv, input logic dwe, input logic [AW-1:0] da,
                        input logic [DW-1:0] dwd, input logic dl);
        logic          locked, e_en, e_we, nprv, ndrv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        int            beats;
        rd_t           rd;
        @(posedge clk);
        #1;
        rst_n      = ~r;
        flush      = f;
        pipe_valid = pv;  pipe_we = pwe;  pipe_addr = pa;  pipe_wdata = pwd;
        dma_valid  = dv;  dma_we  = dwe;  dma_addr  = da;  dma_wdata  = dwd;  dma_last = dl;
        ls_rdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
        cyc++;
        if (r) model_reset();

        locked = (m_beats > 0);
        m_pgnt = 1'b0;
        m_dgnt = 1'b0;
        if (!r) begin
            if (locked)             m_dgnt = dv;
            else if (m_starved && dv) m_dgnt = 1'b1;
            else if (pv && !f)      m_pgnt = 1'b1;
            else                    m_dgnt = dv;
        end
        e_en   = m_pgnt | m_dgnt;
        e_we   = m_pgnt ? pwe : (m_dgnt ? dwe : 1'b0);
        e_addr = m_pgnt ? pa  : (m_dgnt ? da  : '0);
        e_wd   = m_pgnt ? pwd : (m_dgnt ? dwd : '0);

        @(negedge clk);
        chk("pipe_ready",  pipe_ready,  m_pgnt);
        chk("dma_ready",   dma_ready,   m_dgnt);
        chk("ls_en",       ls_en,       e_en);
        chk("ls_we",       ls_we,       e_we);
        chk("ls_addr",     ls_addr,     e_addr);
        chk("ls_wdata",    ls_wdata,    e_wd);
        chk("lock_active", lock_active, locked);
        chk("dma_starved", dma_starved, m_starved);
        chk("pipe_rvalid", pipe_rvalid, e_prv);
        chk("pipe_rdata",  pipe_rdata,  e_prd);
        chk("dma_rvalid",  dma_rvalid,  e_drv);
        chk("dma_rdata",   dma_rdata,   e_drd);

        if (!r) begin
            if (f) begin
                for (int i = pend.size() - 1; i >= 0; i--)
                    if (!pend[i].owner_dma) pend.delete(i);
            end
            nprv = 1'b0;
            ndrv = 1'b0;
            while (pend.size() > 0 && pend[0].cap == cyc) begin
                rd = pend.pop_front();
                if (rd.owner_dma) begin ndrv = 1'b1; e_drd = ls_rdata; end
                else              begin nprv = 1'b1; e_prd = ls_rdata; end
            end
            e_prv = nprv;
            e_drv = ndrv;
            if (e_en && !e_we) begin
                rd.owner_dma = m_dgnt;
                rd.cap       = cyc + RD_LAT;
                pend.push_back(rd);
            end
            if (m_dgnt) begin
                beats   = locked ? m_beats + 1 : 1;
                m_beats = (dl || beats >= LOCK_MAX) ? 0 : beats;
            end else if (locked) begin
                m_beats = 0;
            end
`ifdef LS_ARB_STARVE_GUARD_EN
            if (m_dgnt) begin
                m_waits   = 0;
                m_starved = 1'b0;
            end else if (dv) begin
                m_waits++;
                if (m_waits >= STARVE_MAX) m_starved = 1'b1;
            end
`endif
        end
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic rnd_step(input int pp, input int pd, input int pl, input int pf);
        step(1'b0, ($urandom_range(99) < pf),
             ($urandom_range(99) < pp), $urandom_range(1), AW'($urandom()),
             {$urandom(), $urandom(), $urandom(), $urandom()},
             ($urandom_range(99) < pd), $urandom_range(1), AW'($urandom()),
             {$urandom(), $urandom(), $urandom(), $urandom()},
             ($urandom_range(99) < pl));
    endtask

    logic [DW-1:0] t1_data;
    int            beat, n_dma, n_starved, bound;
    logic          pipe_done, saw_prv, saw_drv;

    initial begin
        model_reset();

        // reset: outputs quiet even with requests present
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 15'h0040, '1, 1'b1, 1'b0, 15'h0100, '1, 1'b0);
        idle_step();

        // pipe load at 0x0040 returns two cycles after the grant
        step(1'b0, 1'b0, 1'b1, 1'b0, 15'h0040, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        chk("t1_ls_en", ls_en, 1'b1);
        chk("t1_ls_addr", ls_addr, 15'h0040);
        idle_step();
        t1_data = ls_rdata;
        idle_step();
        chk("t1_pipe_rvalid", pipe_rvalid, 1'b1);
        chk("t1_pipe_rdata", pipe_rdata, t1_data);
        chk("t1_dma_rvalid", dma_rvalid, 1'b0);

        // simultaneous requests: pipe first, DMA once pipe drops
        step(1'b0, 1'b0, 1'b1, 1'b1, 15'h0010, '1, 1'b1, 1'b1, 15'h0020, '0, 1'b1);
        chk("t2_pipe_first", {pipe_ready, dma_ready}, 2'b10);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 15'h0020, '0, 1'b1);
        chk("t2_dma_next", dma_ready, 1'b1);

        // 12-beat DMA read burst against a waiting pipe store
        beat = 1; n_dma = 0; pipe_done = 1'b0; bound = 0;
        while (beat <= 12 && bound < 60) begin
            step(1'b0, 1'b0, (beat > 1) && !pipe_done, 1'b1, 15'h0300, '1,
                 1'b1, 1'b0, AW'(beat), '0, beat == 12);
            bound++;
            if (pipe_ready) begin
                chk("t3_beats_before_pipe", n_dma, LOCK_MAX);
                pipe_done = 1'b1;
            end
            if (dma_ready) begin
                beat++;
                n_dma++;
            end
        end
        chk("t3_completed", beat, 13);
        chk("t3_pipe_served", pipe_done, 1'b1);
        idle_step();
        chk("t3_unlocked", lock_active, 1'b0);

        // flush kills the pipe load, the concurrent DMA read still returns
        saw_prv = 1'b0; saw_drv = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 15'h0050, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 15'h0060, '0, 1'b1, 1'b0, 15'h0070, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle_step();
            saw_prv |= pipe_rvalid;
            saw_drv |= dma_rvalid;
        end
        chk("t4_no_pipe_rvalid", saw_prv, 1'b0);
        chk("t4_dma_rvalid", saw_drv, 1'b1);

        // both requesters held: guard forces exactly one DMA beat in 20 cycles
        n_dma = 0; n_starved = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 15'h0400, '0, 1'b1, 1'b1, 15'h0500, '0, 1'b1);
            n_dma     += int'(dma_ready);
            n_starved += int'(dma_starved);
        end
`ifdef LS_ARB_STARVE_GUARD_EN
        chk("t5_dma_beats", n_dma, 1);
        chk("t5_starved_cycles", n_starved, 1);
`else
        chk("t5_dma_beats", n_dma, 0);
        chk("t5_starved_cycles", n_starved, 0);
`endif
        for (int i = 0; i < 40; i++) idle_step();

        // randomized traffic, three mixes
        for (int i = 0; i < 400; i++) rnd_step(50, 50, 25, 10);
        for (int i = 0; i < 400; i++) rnd_step(70, 90, 5, 5);
        for (int i = 0; i < 400; i++) rnd_step(30, 80, 50, 20);

        // reset in the middle of a locked burst with reads in flight
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0, 1'b0);
        chk("t6_locked", lock_active, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 15'h0003, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        saw_prv = 1'b0; saw_drv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle_step();
            saw_prv |= pipe_rvalid;
            saw_drv |= dma_rvalid;
        end
        chk("t6_no_rvalid", {saw_prv, saw_drv}, 2'b00);
        chk("t6_unlocked", lock_active, 1'b0);

        for (int i = 0; i < 200; i++) rnd_step(40, 60, 20, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
